// File: rtl/delta_decode8.sv
`default_nettype none
// ============================================================================
//  Module   : delta_decode8
//  Purpose  : Streaming delta decoder. Each accepted encoded sample z yields
//             a = z - prev (mod 2^WIDTH). prev is the previous sample of the
//             same frame, or 0 at frame start. Frames begin on an explicit
//             sof flag or after FRAME_LEN samples. A 2-entry output FIFO with
//             valid/ready on both sides absorbs downstream backpressure.
//  Ports    : clk_i       - clock, rising edge
//             reset_i     - synchronous active-high reset
//             z_i         - encoded sample (running sum)
//             z_valid_i   - z_i / sof_i valid
//             sof_i       - start of frame (base forced to 0 for this sample)
//             z_ready_o   - sample can be accepted this cycle
//             a_o         - decoded delta at the head of the output buffer
//             a_valid_o   - a_o / a_borrow_o / a_last_o valid
//             a_borrow_o  - z < prev (unsigned)
//             a_last_o    - sample is the last of its frame
//             a_ready_i   - downstream accepts the head entry
//  Revision : 1.0 - initial release
// ============================================================================
module delta_decode8 #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] z_i,
   input  logic             z_valid_i,
   input  logic             sof_i,
   output logic             z_ready_o,
   output logic [WIDTH-1:0] a_o,
   output logic             a_valid_o,
   output logic             a_borrow_o,
   output logic             a_last_o,
   input  logic             a_ready_i
);

   // Index needs at least one bit even when every frame is one sample long.
   localparam int               IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic             borrow;
      logic             last;
   } entry_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   buf_state_e       state_q, state_d;
   entry_t           head_q,  head_d;
   entry_t           tail_q,  tail_d;
   logic [WIDTH-1:0] prev_q,  prev_d;
   logic [IDX_W-1:0] idx_q,   idx_d;

   // ---------------------------------------------------------------------
   // Handshakes. z_ready_o depends on registered state only, so there is
   // no combinational path from a_ready_i back to the upstream side.
   // ---------------------------------------------------------------------
   logic push;
   logic pop;

   assign z_ready_o = (state_q != FULL);
   assign a_valid_o = (state_q != EMPTY);
   assign push      = z_valid_i & z_ready_o;
   assign pop       = a_valid_o & a_ready_i;

   assign a_o        = head_q.a;
   assign a_borrow_o = head_q.borrow;
   assign a_last_o   = head_q.last;

   // ---------------------------------------------------------------------
   // Decode datapath
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0] eff_idx;
   logic [WIDTH-1:0] base;
   logic [WIDTH:0]   diff;
   logic [IDX_W-1:0] idx_next;
   entry_t           new_entry;

   always_comb begin
      // sof restarts the frame, so this sample is treated as index 0.
      eff_idx  = sof_i ? '0 : idx_q;
      base     = (eff_idx == '0) ? '0 : prev_q;
      // Two's-complement subtract in WIDTH+1 bits; the top bit is the
      // carry-out, whose inverse is the borrow.
      diff     = {1'b0, z_i} + {1'b0, ~base} + {{WIDTH{1'b0}}, 1'b1};
      idx_next = (eff_idx == LAST_IDX) ? '0 : eff_idx + IDX_W'(1);

      new_entry.a      = diff[WIDTH-1:0];
      new_entry.borrow = ~diff[WIDTH];
      new_entry.last   = (eff_idx == LAST_IDX);
   end

   // ---------------------------------------------------------------------
   // Output buffer next state and frame context
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      prev_d  = prev_q;
      idx_d   = idx_q;

      if (push) begin
         prev_d = z_i;
         idx_d  = idx_next;
      end

      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               head_d  = new_entry;
            end
         end
         ONE: begin
            if (push && pop) begin
               // Head leaves this edge; the new entry replaces it directly.
               head_d = new_entry;
            end else if (push) begin
               state_d = FULL;
               tail_d  = new_entry;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // No push possible here: z_ready_o is low.
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         prev_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         prev_q  <= prev_d;
         idx_q   <= idx_d;
      end
   end

endmodule
`default_nettype wire
